// File: rtl/im2_responder.sv
// rtl/im2_responder.sv - Z80 IM2 interrupt-acknowledge responder with daisy-chain priority and RETI decode
module im2_responder #(
    parameter int NSRC = 4
) (
    input  logic            rst_n,
    input  logic            clk28,
    input  logic [NSRC-1:0] req,
    input  logic [NSRC-1:0] ien,
    input  logic [7:0]      vector_base,
    input  logic            m1,
    input  logic            mreq,
    input  logic            iorq,
    input  logic            rd,
    input  logic [7:0]      d_in,
    output logic [7:0]      d_out,
    output logic            d_oe,
    output logic            n_int_req,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] in_service,
    output logic            reti_stb
);

    typedef enum logic {ST_IDLE, ST_GOT_ED} state_t;

    state_t          state_q, state_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] in_service_q, in_service_d;
    logic [7:0]      d_out_q, d_out_d;
    logic [7:0]      op_q, op_d;
    logic            ack_valid_q, ack_valid_d;
    logic            n_int_req_q, n_int_req_d;
    logic            reti_stb_q, reti_stb_d;
    logic            inta_q, fetch_q;

    logic            inta, inta_rise, fetch, fetch_end;
    logic            elig_any, blocked, ack_fire, reti_hit;
    logic [2:0]      elig_idx;
    logic [NSRC-1:0] ack_mask, reti_mask;

    logic unused_vector_bits;
    assign unused_vector_bits = &{1'b0, vector_base[3:1]};

    assign inta      = m1 & iorq;
    assign inta_rise = inta & ~inta_q;
    assign fetch     = m1 & mreq & rd;
    assign fetch_end = fetch_q & ~fetch;

    // An in-service source blocks itself and everything below it in the chain.
    always_comb begin
        elig_any = 1'b0;
        elig_idx = 3'd0;
        blocked  = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            blocked = blocked | in_service_q[i];
            if (!elig_any && !blocked && pending_q[i]) begin
                elig_any = 1'b1;
                elig_idx = 3'(i);
            end
        end
    end

    always_comb begin
        reti_mask = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (in_service_q[i]) begin
                reti_mask    = '0;
                reti_mask[i] = 1'b1;
            end
        end
    end

    assign ack_fire = inta_rise & elig_any;
    assign ack_mask = ack_fire ? (NSRC'(1) << elig_idx) : '0;

    always_comb begin
        state_d  = state_q;
        reti_hit = 1'b0;
        if (fetch_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (op_q == 8'hED) state_d = ST_GOT_ED;
                end
                ST_GOT_ED: begin
                    if (op_q == 8'h4D) begin
                        state_d  = ST_IDLE;
                        reti_hit = 1'b1;
                    end else if (op_q != 8'hED) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        op_d         = fetch ? d_in : op_q;
        pending_d    = (pending_q & ien & ~ack_mask) | (req & ien);
        in_service_d = (in_service_q | ack_mask) & ~(reti_hit ? reti_mask : '0);
        d_out_d      = ack_fire ? {vector_base[7:4], elig_idx, vector_base[0]} : d_out_q;
        if (inta_rise)
            ack_valid_d = elig_any;
        else
            ack_valid_d = inta & ack_valid_q;
        n_int_req_d  = ~elig_any;
        reti_stb_d   = reti_hit;
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            in_service_q <= '0;
            d_out_q      <= 8'h00;
            op_q         <= 8'h00;
            ack_valid_q  <= 1'b0;
            n_int_req_q  <= 1'b1;
            reti_stb_q   <= 1'b0;
            inta_q       <= 1'b0;
            fetch_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            d_out_q      <= d_out_d;
            op_q         <= op_d;
            ack_valid_q  <= ack_valid_d;
            n_int_req_q  <= n_int_req_d;
            reti_stb_q   <= reti_stb_d;
            inta_q       <= inta;
            fetch_q      <= fetch;
        end
    end

    // Drive enable follows inta combinationally so the bus is released as soon as INTA ends.
    assign d_oe       = inta & ack_valid_q;
    assign d_out      = d_out_q;
    assign n_int_req  = n_int_req_q;
    assign pending    = pending_q;
    assign in_service = in_service_q;
    assign reti_stb   = reti_stb_q;

endmodule

// File: tb/tb_im2_responder.sv
// tb/tb_im2_responder.sv - self-checking bench for im2_responder
module tb_im2_responder;

    logic       rst_n, clk28;
    logic [3:0] req, ien;
    logic [7:0] vector_base, d_in, d_out;
    logic       m1, mreq, iorq, rd;
    logic       d_oe, n_int_req, reti_stb;
    logic [3:0] pending, in_service;

    int errors = 0;
    int checks = 0;

    logic [3:0] m_pend, m_isr;
    logic [7:0] m_dout;
    logic       m_got_ed;

    im2_responder #(.NSRC(4)) dut (
        .rst_n(rst_n), .clk28(clk28), .req(req), .ien(ien),
        .vector_base(vector_base), .m1(m1), .mreq(mreq), .iorq(iorq), .rd(rd),
        .d_in(d_in), .d_out(d_out), .d_oe(d_oe), .n_int_req(n_int_req),
        .pending(pending), .in_service(in_service), .reti_stb(reti_stb)
    );

    initial clk28 = 1'b0;
    always #5 clk28 = ~clk28;

    function automatic int eligible(input logic [3:0] p, input logic [3:0] isr);
        for (int i = 0; i < 4; i++) begin
            if (isr[i]) return -1;
            if (p[i]) return i;
        end
        return -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk28);
            #1;
        end
    endtask

    task automatic model_reset();
        m_pend = 4'h0; m_isr = 4'h0; m_dout = 8'h00; m_got_ed = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; req = 4'h0; m1 = 0; mreq = 0; iorq = 0; rd = 0; d_in = 8'h00;
        model_reset();
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic do_req(input logic [3:0] mask, input string tag);
        req = mask;
        tick(1);
        req = 4'h0;
        m_pend = m_pend | (mask & ien);
        checks++;
        if (pending !== m_pend) begin
            errors++;
            $display("FAIL %s pending: got %h want %h", tag, pending, m_pend);
        end
        tick(1);
        checks++;
        if (n_int_req !== (eligible(m_pend, m_isr) < 0)) begin
            errors++;
            $display("FAIL %s n_int_req: got %b want %b", tag, n_int_req, eligible(m_pend, m_isr) < 0);
        end
    endtask

    task automatic do_inta(input string tag);
        int s;
        s = eligible(m_pend, m_isr);
        m1 = 1; iorq = 1;
        tick(1);
        if (s >= 0) begin
            m_pend[s] = 1'b0;
            m_isr[s]  = 1'b1;
            m_dout    = {vector_base[7:4], 3'(s), vector_base[0]};
        end
        checks++;
        if (d_oe !== (s >= 0) || d_out !== m_dout) begin
            errors++;
            $display("FAIL %s vector: d_oe=%b d_out=%h want d_oe=%b d_out=%h", tag, d_oe, d_out, s >= 0, m_dout);
        end
        checks++;
        if (in_service !== m_isr || pending !== m_pend) begin
            errors++;
            $display("FAIL %s ack state: isr=%h pend=%h want isr=%h pend=%h", tag, in_service, pending, m_isr, m_pend);
        end
        tick(1);
        checks++;
        if (n_int_req !== (eligible(m_pend, m_isr) < 0) || d_oe !== (s >= 0)) begin
            errors++;
            $display("FAIL %s post-ack: n_int_req=%b d_oe=%b want %b %b", tag, n_int_req, d_oe, eligible(m_pend, m_isr) < 0, s >= 0);
        end
        m1 = 0; iorq = 0;
        #1;
        checks++;
        if (d_oe !== 1'b0) begin
            errors++;
            $display("FAIL %s d_oe release: got %b want 0", tag, d_oe);
        end
        tick(1);
    endtask

    task automatic do_fetch(input logic [7:0] op, input logic is_m1, input string tag);
        logic exp_reti;
        exp_reti = 1'b0;
        if (is_m1) begin
            exp_reti = m_got_ed && (op == 8'h4D);
            m_got_ed = (op == 8'hED);
        end
        m1 = is_m1; mreq = 1; rd = 1; d_in = op;
        tick(2);
        m1 = 0; mreq = 0; rd = 0; d_in = 8'h00;
        tick(1);
        if (exp_reti) begin
            for (int i = 0; i < 4; i++) begin
                if (m_isr[i]) begin
                    m_isr[i] = 1'b0;
                    break;
                end
            end
        end
        checks++;
        if (reti_stb !== exp_reti || in_service !== m_isr) begin
            errors++;
            $display("FAIL %s reti: stb=%b isr=%h want stb=%b isr=%h", tag, reti_stb, in_service, exp_reti, m_isr);
        end
        tick(1);
        checks++;
        if (reti_stb !== 1'b0 || n_int_req !== (eligible(m_pend, m_isr) < 0)) begin
            errors++;
            $display("FAIL %s after reti: stb=%b n_int_req=%b want 0 %b", tag, reti_stb, n_int_req, eligible(m_pend, m_isr) < 0);
        end
    endtask

    task automatic do_reti(input string tag);
        do_fetch(8'hED, 1'b1, tag);
        do_fetch(8'h4D, 1'b1, tag);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (pending !== 4'h0 || in_service !== 4'h0 || n_int_req !== 1'b1 ||
            d_out !== 8'h00 || d_oe !== 1'b0 || reti_stb !== 1'b0) begin
            errors++;
            $display("FAIL reset: pend=%h isr=%h nint=%b dout=%h doe=%b stb=%b want 0 0 1 00 0 0",
                     pending, in_service, n_int_req, d_out, d_oe, reti_stb);
        end
    endtask

    task automatic test_basic();
        ien = 4'hF; vector_base = 8'hE0;
        do_req(4'b0100, "basic_req");
        do_inta("basic_inta");
        checks++;
        if (d_out !== 8'hE4) begin
            errors++;
            $display("FAIL basic_vector: got %h want e4", d_out);
        end
        do_reti("basic_reti");
    endtask

    task automatic test_priority();
        vector_base = 8'hF1;
        do_req(4'b1010, "prio_req");
        do_inta("prio_inta1");
        checks++;
        if (d_out !== 8'hF3) begin
            errors++;
            $display("FAIL prio_first: got %h want f3", d_out);
        end
        do_reti("prio_reti1");
        do_inta("prio_inta2");
        checks++;
        if (d_out !== 8'hF7) begin
            errors++;
            $display("FAIL prio_second: got %h want f7", d_out);
        end
        do_reti("prio_reti2");
    endtask

    task automatic test_nesting();
        vector_base = 8'hE0;
        do_req(4'b0010, "nest_req1");
        do_inta("nest_inta1");
        do_req(4'b0001, "nest_req0");
        do_inta("nest_inta0");
        do_reti("nest_reti0");
        do_req(4'b0100, "nest_req2_blocked");
        checks++;
        if (n_int_req !== 1'b1) begin
            errors++;
            $display("FAIL nest_blocked: n_int_req=%b want 1", n_int_req);
        end
        do_reti("nest_reti1");
        do_inta("nest_inta2");
        do_reti("nest_reti2");
    endtask

    task automatic test_reti_decode();
        do_req(4'b0011, "dec_req");
        do_inta("dec_inta0");
        do_fetch(8'hED, 1'b1, "dec_ed_ed_4d");
        do_fetch(8'hED, 1'b1, "dec_ed_ed_4d");
        do_fetch(8'h4D, 1'b1, "dec_ed_ed_4d");
        do_inta("dec_inta1");
        do_fetch(8'hED, 1'b1, "dec_retn");
        do_fetch(8'h45, 1'b1, "dec_retn");
        do_fetch(8'hED, 1'b0, "dec_operand");
        do_fetch(8'h4D, 1'b1, "dec_operand");
        checks++;
        if (in_service !== 4'b0010) begin
            errors++;
            $display("FAIL dec_no_clear: isr=%h want 2", in_service);
        end
        do_reti("dec_cleanup");
        do_reti("dec_empty");
    endtask

    task automatic test_spurious_and_ien();
        do_inta("spurious");
        ien = 4'b1101;
        do_req(4'b0010, "ien_drop");
        do_req(4'b1000, "ien_keep");
        ien = 4'b0101;
        tick(1);
        m_pend = m_pend & ien;
        checks++;
        if (pending !== m_pend) begin
            errors++;
            $display("FAIL ien_clear: pending=%h want %h", pending, m_pend);
        end
        ien = 4'hF;
        tick(1);
    endtask

    task automatic test_reset_mid_inta();
        do_req(4'b0010, "rst_req");
        m1 = 1; iorq = 1;
        tick(2);
        checks++;
        if (d_oe !== 1'b1 || in_service !== 4'b0010) begin
            errors++;
            $display("FAIL rst_setup: d_oe=%b isr=%h want 1 2", d_oe, in_service);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (d_oe !== 1'b0 || in_service !== 4'h0 || pending !== 4'h0 || n_int_req !== 1'b1 ||
            d_out !== 8'h00 || reti_stb !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_inta: doe=%b isr=%h pend=%h nint=%b dout=%h stb=%b want 0 0 0 1 00 0",
                     d_oe, in_service, pending, n_int_req, d_out, reti_stb);
        end
        m1 = 0; iorq = 0;
        model_reset();
        tick(1);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_random();
        logic [7:0] ops [4];
        ops[0] = 8'hED; ops[1] = 8'h4D; ops[2] = 8'h45; ops[3] = 8'h00;
        for (int it = 0; it < 60; it++) begin
            vector_base = 8'($urandom);
            case ($urandom_range(0, 4))
                0: do_req(4'($urandom), "rnd_req");
                1: do_inta("rnd_inta");
                2: do_reti("rnd_reti");
                3: do_fetch((ops[$urandom_range(0, 3)]) ^ 8'($urandom_range(0, 1) * 8'h10),
                            1'($urandom_range(0, 1)), "rnd_fetch");
                default: begin
                    ien = 4'($urandom);
                    tick(1);
                    m_pend = m_pend & ien;
                    checks++;
                    if (pending !== m_pend) begin
                        errors++;
                        $display("FAIL rnd_ien: pending=%h want %h", pending, m_pend);
                    end
                end
            endcase
        end
        ien = 4'hF;
        tick(1);
    endtask

    initial begin
        ien = 4'hF; vector_base = 8'h00;
        test_reset();
        test_basic();
        test_priority();
        test_nesting();
        test_reti_decode();
        test_spurious_and_ien();
        test_reset_mid_inta();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/im2_responder.md
# im2_responder

Interrupt-acknowledge responder for the Z80 IM2 side of the CPU interface. It holds prioritised interrupt requests from peripheral sources and asserts a registered INT request toward the CPU control logic. On the CPU's acknowledge cycle (M1+IORQ) it places a per-source vector on the data bus, then decodes the RETI opcode stream to retire the in-service source. It sits between the peripheral request strobes and the CPU data-bus mux.

## Interface
- NSRC, 4, number of interrupt sources (1..8); index 0 is the highest priority.
- rst_n  in  1  asynchronous active-low reset
- clk28  in  1  system clock; all state is on the posedge
- req  in  NSRC  single-clk28 request strobes, one per source
- ien  in  NSRC  per-source enable mask
- vector_base  in  8  IM2 vector base; bits [7:4] and [0] are used
- m1, mreq, iorq, rd  in  1 each  CPU bus strobes, active-high, already synchronous to clk28
- d_in  in  8  CPU data bus, read side
- d_out  out  8  vector byte, registered
- d_oe  out  1  vector drive enable toward the data-bus mux
- n_int_req  out  1  active-low interrupt request, registered
- pending  out  NSRC  pending register, for status reads
- in_service  out  NSRC  in-service register
- reti_stb  out  1  one-clk28 pulse when RETI is decoded

## Operation
- pending: next = (pending & ien & ~ack_clr) | (req & ien).
  - A req on a disabled source is dropped.
  - Clearing an ien bit clears that source's pending bit.
  - A req coinciding with its own acknowledge leaves the bit set, because set wins over clear.
- Eligible source: the lowest index i with pending[i]=1 and no in_service bit at an index ≤ i (daisy-chain rule). An in-service source blocks itself and every lower-priority source.
- n_int_req is registered: 0 when any source is eligible, else 1.
- INTA detection: inta = m1 & iorq. inta_rise = inta & ~inta_q, where inta_q is the value registered on the previous clk28.
- On inta_rise with an eligible source s:
  - ack_valid ← 1
  - d_out ← {vector_base[7:4], s[2:0], vector_base[0]}
  - pending[s] cleared (ack_clr), in_service[s] set
- On inta_rise with no eligible source (spurious, or another INT source): ack_valid ← 0, no state change, d_oe stays 0 so the bus floats to FFh.
- d_oe = inta & ack_valid. ack_valid clears on the first clk28 with inta=0.
- RETI decoder (opcode fetches only):
  - fetch = m1 & mreq & rd.
  - d_in is captured into op on every clk28 while fetch=1.
  - A fetch ends on a clk28 where fetch_q=1 and fetch=0; op is evaluated then.
  - States:
    - IDLE: op=EDh → GOT_ED; otherwise stay in IDLE.
    - GOT_ED: op=4Dh → IDLE with the RETI action; op=EDh → stay in GOT_ED; anything else → IDLE.
  - Non-M1 reads (operands, data) never advance the FSM.
- RETI action: clear the lowest-index set bit of in_service and pulse reti_stb. With in_service all zero, only reti_stb pulses.
- RETN (ED 45h) and other ED-page opcodes do not affect in_service.

## Timing
- Reset values: pending=0, in_service=0, n_int_req=1, d_out=00h, d_oe=0, reti_stb=0, FSM=IDLE, ack_valid=0, inta_q=0, fetch_q=0, op=00h.
- Reset is honoured mid-cycle: asserting it during INTA drops d_oe immediately.
- req pulse at clk28 edge N: pending set at N+1, n_int_req low at N+2.
- inta rises at edge N: d_out and ack_valid valid after edge N+1, so d_oe goes high after N+1 while inta holds. n_int_req goes high at N+2 if nothing else is eligible.
- d_oe falls combinationally with inta.
- RETI: the 4Dh fetch ends at edge N. in_service clears and reti_stb is high after N+1; n_int_req can reassert at N+2.
- The responder takes no part in CPU clock wait or contention. It relies on inta lasting ≥2 clk28, which all turbo modes satisfy.

## Test plan
- Reset then req[2] pulse, ien=Fh, vector_base=E0h → pending=4h, n_int_req=0 two clks later; INTA → d_oe=1, d_out=E4h, in_service=4h, n_int_req=1.
- req[3] and req[1] in the same clk, vector_base=F1h → first INTA gives F3h (source 1). After RETI (ED,4D fetches) → reti_stb pulse, second INTA gives F7h.
- With in_service[1] set, req[0] → n_int_req=0 and INTA gives source 0 (nesting). req[2] while in_service[1] → n_int_req stays 1 until RETI.
- Fetch sequence ED,ED,4D → one RETI. Sequence ED,45 → no clear. Operand read of ED then M1 fetch of 4D → no RETI.
- INTA with pending=0 → d_oe stays 0, no state change. req[1] with ien[1]=0 → pending unchanged.
- Assert rst_n low during active INTA with in_service=2h → d_oe=0 immediately; all registers at reset values; n_int_req=1.
